// File: rtl/alu_shift_pipe.sv
// rtl/alu_shift_pipe.sv - two-stage valid/ready shift unit (SLL/SRL/SRA/ROL) built on a 32-bit left-shift core

// Combinational 32-bit logarithmic left shifter: five mux stages of 1/2/4/8/16 bits.
module lsh32 (
    input  logic [31:0] data,
    input  logic [4:0]  cnt,
    output logic [31:0] res
);
    logic [31:0] st1;
    logic [31:0] st2;
    logic [31:0] st3;
    logic [31:0] st4;

    assign st1 = cnt[0] ? {data[30:0], 1'b0}  : data;
    assign st2 = cnt[1] ? {st1[29:0], 2'b0}   : st1;
    assign st3 = cnt[2] ? {st2[27:0], 4'b0}   : st2;
    assign st4 = cnt[3] ? {st3[23:0], 8'b0}   : st3;
    assign res = cnt[4] ? {st4[15:0], 16'b0}  : st4;
endmodule

module alu_shift_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [4:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_cnt
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    logic        s1_valid;
    logic [1:0]  s1_op;
    logic [31:0] s1_a;
    logic [4:0]  s1_b;
    logic        s2_valid;

    logic adv1;
    logic adv2;
    logic in_fire;
    logic out_fire;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = adv2;
    assign in_ready  = !s1_valid || adv1;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Stage 1: request register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 2'b00;
            s1_a     <= 32'h0;
            s1_b     <= 5'h0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    // Right shifts reuse the left core on bit-reversed operands.
    logic [31:0] a_rev;
    logic [5:0]  rot_amt;
    logic [31:0] lsh_a;
    logic [31:0] lsh_ra;
    logic [31:0] lsh_ones;
    logic [31:0] lsh_rot;

    assign a_rev   = rev32(s1_a);
    assign rot_amt = 6'd32 - {1'b0, s1_b};

    lsh32 u_core_sll  (.data(s1_a),          .cnt(s1_b),         .res(lsh_a));
    lsh32 u_core_srl  (.data(a_rev),         .cnt(s1_b),         .res(lsh_ra));
    lsh32 u_core_mask (.data(32'hFFFF_FFFF), .cnt(s1_b),         .res(lsh_ones));
    lsh32 u_core_rot  (.data(a_rev),         .cnt(rot_amt[4:0]), .res(lsh_rot));

    logic [31:0] srl_val;
    logic [31:0] sra_fill;
    logic [31:0] rol_hi;
    logic [31:0] result;

    assign srl_val  = rev32(lsh_ra);
    assign sra_fill = s1_a[31] ? ~rev32(lsh_ones) : 32'h0;
    assign rol_hi   = (s1_b == 5'd0) ? 32'h0 : rev32(lsh_rot);

    always_comb begin
        result = 32'h0;
        case (s1_op)
            OP_SLL:  result = lsh_a;
            OP_SRL:  result = srl_val;
            OP_SRA:  result = srl_val | sra_fill;
            OP_ROL:  result = lsh_a | rol_hi;
            default: result = 32'h0;
        endcase
    end

    // Stage 2: result register; data only moves when a real op advances so a bubble leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_res  <= 32'h0;
            out_zero <= 1'b1;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res  <= result;
                out_zero <= (result == 32'h0);
            end
        end
    end

    // A transfer in the flush cycle still happened downstream, so it is counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (out_fire) begin
            op_cnt <= op_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb/tb_alu_shift_pipe.sv - scoreboard bench for alu_shift_pipe with a behavioural shift model
module tb_alu_shift_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_zero;
    logic [15:0] op_cnt;

    alu_shift_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_zero(out_zero),
        .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = 16'h0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_res = 32'h0;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
        logic [63:0] d;
        logic [31:0] r;
        case (op)
            2'd0: r = a << b;
            2'd1: r = a >> b;
            2'd2: r = $signed(a) >>> b;
            default: begin
                d = {a, a} << b;
                r = d[63:32];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: transfers are decided by values stable across the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 16'h0;
            stall_seen = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            if (stall_seen) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_res", out_res, stall_res);
            end
            stall_seen = out_valid && !out_ready && !flush;
            stall_res  = out_res;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("out_res", out_res, e);
                    check("out_zero", 32'(out_zero), 32'(e == 32'h0));
                end
                check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_expect(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [4:0] b, input logic [31:0] req);
        int lat;
        lat = -1;
        send(op, a, b);
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                check(name, out_res, req);
                check({name, "_zero"}, 32'(out_zero), 32'(req == 32'h0));
            end
        end
        check({name, "_latency"}, lat, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        in_op = 2'd0;
        in_a = 32'h0;
        in_b = 5'd0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_out_res", out_res, 32'd0);
        @(posedge clk);
        #1;

        // Directed operands
        send_expect("sll_31",  2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000);
        send_expect("sra_4",   2'd2, 32'hF000_0000, 5'd4,  32'hFF00_0000);
        send_expect("srl_4",   2'd1, 32'hF000_0000, 5'd4,  32'h0F00_0000);
        send_expect("sra_0",   2'd2, 32'h8000_0000, 5'd0,  32'h8000_0000);
        send_expect("rol_1",   2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003);
        send_expect("rol_0",   2'd3, 32'h1234_5678, 5'd0,  32'h1234_5678);
        send_expect("sll_0",   2'd0, 32'h0000_0001, 5'd0,  32'h0000_0001);
        send_expect("sll_zero",2'd0, 32'h0000_0000, 5'd5,  32'h0000_0000);
        send_expect("srl_31",  2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001);
        send_expect("rol_31",  2'd3, 32'h0000_0003, 5'd31, 32'h8000_0001);

        // Back-to-back 8 ops with a 5-cycle downstream stall
        do_reset();
        fork
            begin
                for (int k = 0; k < 8; k++) send(2'($urandom_range(0, 3)), $urandom, 5'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("burst_op_cnt", 32'(op_cnt), 32'd8);

        // Flush with both stages full; the request offered in the flush cycle is dropped
        out_ready = 1'b0;
        send(2'd0, 32'h1, 5'd1);
        send(2'd1, 32'h80, 5'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 2'd3;
        in_a = 32'hDEAD_BEEF;
        in_b = 5'd4;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("flush_no_emit", 32'(out_valid), 32'd0);
        check("flush_op_cnt", 32'(op_cnt), 32'd8);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional flush
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            in_b      = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31)
                                                    : 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        drain();

        // Asynchronous reset with ops in flight
        out_ready = 1'b0;
        send(2'd0, 32'hFFFF_FFFF, 5'd3);
        send(2'd2, 32'h8000_0000, 5'd7);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_op_cnt", 32'(op_cnt), 32'd0);
        check("arst_out_zero", 32'(out_zero), 32'd1);
        check("arst_out_res", out_res, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_emit", 32'(out_valid), 32'd0);

        // op_cnt wrap past 0xFFFF
        @(posedge clk);
        #1;
        for (int c = 0; c < 65539; c++) begin
            in_valid = 1'b1;
            in_op = 2'($urandom_range(0, 3));
            in_a = $urandom;
            in_b = 5'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        check("wrap_op_cnt", 32'(op_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
